// File: rtl/vkey_pkg.sv
// Shared types and helpers for the virtual 5x5 key-matrix responder.
// Key index mapping: col = code / 5, row = code % 5.
package vkey_pkg;

  localparam int KEY_ROWS = 5;
  localparam int KEY_COLS = 5;
  localparam int KEY_MAX  = 24;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_ON,
    HOLD,
    BOUNCE_OFF,
    GAP
  } state_t;

  typedef struct packed {
    logic [4:0] code;
    logic [7:0] hold;
  } cmd_t;

  typedef struct packed {
    logic [2:0] col;
    logic [2:0] row;
  } rc_t;

  function automatic rc_t code_to_rc(input logic [4:0] code);
    rc_t rc;
    rc.col = 3'(code / 5'd5);
    rc.row = 3'(code % 5'd5);
    return rc;
  endfunction

endpackage

// File: rtl/vkey_cmd_fifo.sv
// Key-press command queue: {code, hold} entries, power-of-2 depth.
// Flush empties the queue in one clock and wins over push/pop.
module vkey_cmd_fifo
  import vkey_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  cmd_t          din,
  output cmd_t          dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  // Pointers and occupancy; push+pop together leave level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      level <= level + LW'(wr) - LW'(rd);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/vkey_matrix_drv.sv
// Virtual key-matrix responder: plays queued key presses back to a
// column-strobing scanner as active-low row returns.
module vkey_matrix_drv
  import vkey_pkg::*;
#(
  parameter int HOLD_UNIT  = 2_000_000,
  parameter int BOUNCE_N   = 4,
  parameter int BOUNCE_CYC = 50_000,
  parameter int GAP_CYC    = 4_000_000,
  parameter int QDEPTH     = 4
) (
  input  logic                clk,
  input  logic                RSTN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_code,
  input  logic [7:0]          cmd_hold,
  input  logic                abort,
  input  logic [KEY_COLS-1:0] Key_x,
  output logic [KEY_ROWS-1:0] Key_y,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          level
);

  localparam logic [31:0] B_LAST = 32'(BOUNCE_CYC - 1);
  localparam logic [31:0] G_LAST = 32'(GAP_CYC - 1);
  localparam logic [7:0]  P_LAST = 8'(BOUNCE_N - 1);
  localparam state_t AFTER_POP  =
    (BOUNCE_N > 0) ? BOUNCE_ON : HOLD;
  localparam state_t AFTER_HOLD =
    (BOUNCE_N > 0) ? BOUNCE_OFF : GAP;

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic [31:0] hold_len;
  logic [7:0]  ph;
  logic [7:0]  ph_n;
  rc_t         rc_q;
  logic        live;
  logic        live_n;
  logic        done_n;
  logic        pop;
  logic        push;
  logic        full;
  logic        empty;
  logic        closed;
  cmd_t        head;
  cmd_t        din;

  assign din       = cmd_t'({cmd_code, cmd_hold});
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready
                     && (cmd_code <= 5'(KEY_MAX));
  assign busy      = (state != IDLE) || (level != '0);

  assign closed = !abort && (
      (state == HOLD)
   || (state == BOUNCE_ON  && !ph[0])
   || (state == BOUNCE_OFF &&  ph[0]));

  vkey_cmd_fifo #(
    .DEPTH (QDEPTH),
    .LW    (3)
  ) u_fifo (
    .clk   (clk),
    .rst_n (RSTN),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (din),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Press sequencer: next state, counters and done request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    live_n  = live;
    done_n  = 1'b0;
    pop     = 1'b0;
    if (abort) begin
      state_n = GAP;
      cnt_n   = '0;
      ph_n    = '0;
      live_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            live_n  = 1'b1;
            cnt_n   = '0;
            ph_n    = '0;
            state_n = AFTER_POP;
          end
        end
        BOUNCE_ON, BOUNCE_OFF: begin
          if (cnt == B_LAST) begin
            cnt_n = '0;
            if (ph == P_LAST) begin
              ph_n    = '0;
              state_n = (state == BOUNCE_ON) ? HOLD : GAP;
            end else begin
              ph_n = ph + 8'd1;
            end
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        HOLD: begin
          if (cnt == hold_len - 32'd1) begin
            cnt_n   = '0;
            state_n = AFTER_HOLD;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == G_LAST) begin
            cnt_n   = '0;
            done_n  = live;
            live_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Sequencer state, latched key position and hold length.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      cnt      <= '0;
      ph       <= '0;
      live     <= 1'b0;
      done     <= 1'b0;
      rc_q     <= '0;
      hold_len <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ph    <= ph_n;
      live  <= live_n;
      done  <= done_n;
      if (pop) begin
        rc_q     <= code_to_rc(head.code);
        hold_len <= ((head.hold == 8'd0) ? 32'd1
                     : 32'(head.hold)) * 32'(HOLD_UNIT);
      end
    end
  end

  // Reject pulse for out-of-range key codes.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) err <= 1'b0;
    else err <= cmd_valid && cmd_ready
                && (cmd_code > 5'(KEY_MAX));
  end

  // Row return: one clock behind the column drive.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      Key_y <= '1;
    end else begin
      Key_y <= '1;
      if (closed && !Key_x[rc_q.col]) Key_y[rc_q.row] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vkey_matrix_drv.sv
// Bench for vkey_matrix_drv: scoreboarded presses on a clean-edge
// instance plus a contact-bounce instance.
module tb_vkey_matrix_drv;

  localparam int HU = 10;
  localparam int BC = 3;
  localparam int GC = 20;

  logic clk = 1'b0;
  logic RSTN = 1'b0;

  logic       cmd_valid0, cmd_ready0, abort0;
  logic [4:0] cmd_code0, Key_x0, Key_y0;
  logic [7:0] cmd_hold0;
  logic       busy0, done0, err0;
  logic [2:0] level0;

  logic       cmd_valid1, cmd_ready1, abort1;
  logic [4:0] cmd_code1, Key_x1, Key_y1;
  logic [7:0] cmd_hold1;
  logic       busy1, done1, err1;
  logic [2:0] level1;

  always #5 clk = ~clk;

  vkey_matrix_drv #(
    .HOLD_UNIT (HU), .BOUNCE_N (0), .BOUNCE_CYC (BC),
    .GAP_CYC (GC), .QDEPTH (4)
  ) dut0 (
    .clk (clk), .RSTN (RSTN),
    .cmd_valid (cmd_valid0), .cmd_ready (cmd_ready0),
    .cmd_code (cmd_code0), .cmd_hold (cmd_hold0),
    .abort (abort0), .Key_x (Key_x0), .Key_y (Key_y0),
    .busy (busy0), .done (done0), .err (err0),
    .level (level0)
  );

  vkey_matrix_drv #(
    .HOLD_UNIT (HU), .BOUNCE_N (2), .BOUNCE_CYC (BC),
    .GAP_CYC (GC), .QDEPTH (4)
  ) dut1 (
    .clk (clk), .RSTN (RSTN),
    .cmd_valid (cmd_valid1), .cmd_ready (cmd_ready1),
    .cmd_code (cmd_code1), .cmd_hold (cmd_hold1),
    .abort (abort1), .Key_x (Key_x1), .Key_y (Key_y1),
    .busy (busy1), .done (done1), .err (err1),
    .level (level1)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
  endtask

  // Expected outcome of one press, checked when done pulses.
  typedef struct {
    logic [4:0] y;
    int         len;
    bit         dc;
  } exp_t;

  exp_t sb[$];
  int   err_seen  = 0;
  int   done_seen = 0;

  // Row pattern of a key seen with all columns driven low.
  function automatic logic [4:0] row_mask(input int code);
    return ~(5'(1) << (code % 5));
  endfunction

  function automatic int hold_cycles(input int h);
    return ((h == 0) ? 1 : h) * HU;
  endfunction

  // Monitor: measures each low run of Key_y and the release-to-done
  // distance, and scores them against the queue at each done.
  logic [4:0] prev_y = 5'h1f;
  logic [4:0] obs_y  = 5'h1f;
  int run_len = 0, obs_len = 0, since_rise = 0;
  exp_t e;

  always @(negedge clk) begin
    if (RSTN) begin
      if (abort0) begin
        run_len = 0;
        obs_len = 0;
        obs_y   = 5'h1f;
      end else if (Key_y0 != 5'h1f) begin
        if (run_len == 0) obs_y = Key_y0;
        run_len++;
      end else if (prev_y != 5'h1f) begin
        obs_len    = run_len;
        run_len    = 0;
        since_rise = 0;
      end else begin
        since_rise++;
      end
      prev_y = Key_y0;
      if (err0) err_seen++;
      if (done0) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("done_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          if (!e.dc) begin
            check("press_rows", obs_y, e.y);
            check("press_len", obs_len, e.len);
            if (e.len > 0)
              check("release_to_done", since_rise, GC - 1);
          end
        end
        obs_len = 0;
        obs_y   = 5'h1f;
      end
    end
  end

  task automatic push0(input logic [4:0] c, input logic [7:0] h);
    int n;
    n = 0;
    cmd_code0  = c;
    cmd_hold0  = h;
    cmd_valid0 = 1'b1;
    while (!cmd_ready0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_timeout", n, 0);
    @(negedge clk);
    cmd_valid0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 || sb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_busy"}, busy0, 0);
    check({name, "_pending"}, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, h, e_base, err_exp, d_before, n;
    int runs[$];
    bit trace[$];
    bit other_low;
    int exp_r[6];

    cmd_valid0 = 0; cmd_code0 = 0; cmd_hold0 = 0;
    abort0 = 0; Key_x0 = 5'h1f;
    cmd_valid1 = 0; cmd_code1 = 0; cmd_hold1 = 0;
    abort1 = 0; Key_x1 = 5'h1f;

    repeat (3) @(negedge clk);
    check("rst_key_y", Key_y0, 5'h1f);
    check("rst_ready", cmd_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_level", level0, 0);
    check("rst_key_y_b", Key_y1, 5'h1f);
    RSTN = 1'b1;
    @(negedge clk);

    // Code 7 (col 1, row 2) strobed on its column.
    Key_x0 = 5'b11101;
    sb.push_back('{y: 5'b11011, len: 30, dc: 0});
    push0(5'd7, 8'd3);
    wait_idle0("single");

    // Same key while a different column is strobed.
    Key_x0 = 5'b11110;
    sb.push_back('{y: 5'h1f, len: 0, dc: 0});
    push0(5'd7, 8'd3);
    wait_idle0("other_col");

    // Code 24: row follows Key_x with one clock latency.
    Key_x0 = 5'h1f;
    sb.push_back('{y: 5'h1f, len: 0, dc: 1});
    push0(5'd24, 8'd2);
    repeat (4) @(negedge clk);
    check("c24_idle_cols", Key_y0, 5'h1f);
    Key_x0 = 5'b00000;
    @(negedge clk);
    check("c24_all_low", Key_y0, 5'b01111);
    Key_x0 = 5'h1f;
    @(negedge clk);
    check("c24_released", Key_y0, 5'h1f);
    wait_idle0("c24");

    // Five back-to-back presses fill the queue behind the first.
    Key_x0 = 5'b00000;
    foreach (exp_r[i]) exp_r[i] = 0;
    for (int i = 0; i < 5; i++) begin
      c = (i == 0) ? 3 : (i == 1) ? 9 : (i == 2) ? 10
        : (i == 3) ? 16 : 22;
      sb.push_back('{y: row_mask(c), len: hold_cycles(1),
                     dc: 0});
      push0(5'(c), 8'd1);
    end
    check("fill_level", level0, 4);
    check("fill_ready", cmd_ready0, 0);
    wait_idle0("fill");
    check("fill_level_end", level0, 0);

    // Out-of-range code is rejected without a press.
    e_base = err_seen;
    d_before = done_seen;
    push0(5'd25, 8'd1);
    repeat (2) @(negedge clk);
    check("bad_err", err_seen - e_base, 1);
    check("bad_level", level0, 0);
    check("bad_busy", busy0, 0);
    repeat (40) @(negedge clk);
    check("bad_no_done", done_seen, d_before);

    // Abort during hold with two presses queued.
    d_before = done_seen;
    push0(5'd1, 8'd5);
    push0(5'd2, 8'd1);
    push0(5'd3, 8'd1);
    check("abort_queued", level0, 2);
    repeat (5) @(negedge clk);
    check("abort_pressing", Key_y0, row_mask(1));
    abort0 = 1'b1;
    @(negedge clk);
    check("abort_key_y", Key_y0, 5'h1f);
    check("abort_level", level0, 0);
    check("abort_ready", cmd_ready0, 0);
    abort0 = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_gap_busy", busy0, 1);
    @(negedge clk);
    check("abort_idle", busy0, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_seen, d_before);

    // Random presses, including rejected codes and zero holds.
    Key_x0 = 5'b00000;
    e_base = err_seen;
    err_exp = 0;
    for (int i = 0; i < 14; i++) begin
      c = int'($urandom_range(0, 27));
      h = int'($urandom_range(0, 3));
      if (c <= 24)
        sb.push_back('{y: row_mask(c), len: hold_cycles(h),
                       dc: 0});
      else
        err_exp++;
      push0(5'(c), 8'(h));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle0("random");
    check("random_err", err_seen - e_base, err_exp);

    // Bouncing contact on the second instance, code 0.
    Key_x1 = 5'b11110;
    cmd_code1 = 5'd0;
    cmd_hold1 = 8'd1;
    cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    n = 0;
    other_low = 0;
    while (!done1 && n < 300) begin
      trace.push_back(Key_y1[0]);
      if (Key_y1[4:1] != 4'hf) other_low = 1;
      @(negedge clk);
      n++;
    end
    check("bounce_done", done1, 1);
    check("bounce_other_rows", other_low, 0);
    foreach (trace[i]) begin
      if (i == 0 || trace[i] != trace[i-1]) runs.push_back(1);
      else runs[runs.size()-1]++;
    end
    if (runs.size() > 0 && trace[0]) void'(runs.pop_front());
    exp_r = '{BC, BC, hold_cycles(1), BC, BC, GC - 1};
    check("bounce_runs", runs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bounce_run%0d", i),
            (i < runs.size()) ? runs[i] : -1, exp_r[i]);
    end

    // Asynchronous reset mid-press releases the row at once.
    repeat (3) @(negedge clk);
    Key_x1 = 5'b00000;
    cmd_code1 = 5'd12;
    cmd_hold1 = 8'd2;
    cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_pressing", Key_y1, row_mask(12));
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_mid_key_y", Key_y1, 5'h1f);
    check("rst_mid_busy", busy1, 0);
    repeat (2) @(negedge clk);
    RSTN = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
